// File: rtl/alu_mc_pipe.sv
// alu_mc_pipe: width-generic multi-cycle ALU with a start/done handshake.
// Single-cycle logic ops, iterative shift-add MUL and restoring DIV (one bit per
// cycle), error reporting, power-abort and an output isolation clamp.
// Optional feature: define ALU_FLAGS_EN to build the {N,Z,C,V} flag register;
// otherwise flags is tied to zero.
module alu_mc_pipe #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] ISO_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_pwr_en,
  input  logic             iso_en,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [3:0]       flags
);
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL_EXEC, DIV_EXEC} state_t;

  state_t             state;
  logic [SW-1:0]      cnt;
  // MUL: {partial high, multiplier}; DIV: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   result_r, result_hi_r;
  logic               done_r, err_r;

  logic               run, accept, last;
  logic [WIDTH-1:0]   sc_res;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] div_next;

  assign run    = (state != IDLE);
  assign accept = start & ~run & alu_pwr_en & ~iso_en;
  assign last   = (cnt == SW'(WIDTH-1));

  // single-cycle operation result, computed straight from the inputs at accept
  always_comb begin
    sc_res = '0;
    case (opcode)
      4'd0:    sc_res = A + B;
      4'd1:    sc_res = A - B;
      4'd2:    sc_res = A & B;
      4'd3:    sc_res = A | B;
      4'd4:    sc_res = A ^ B;
      4'd5:    sc_res = ~(A | B);
      4'd6:    sc_res = A << B[SW-1:0];
      4'd7:    sc_res = ~(A ^ B);
      default: sc_res = '0;
    endcase
  end

  // one iteration of shift-add multiply and restoring divide
  always_comb begin
    mul_sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, b_r} : '0);
    mul_next = {mul_sum, p[WIDTH-1:1]};
    div_sh   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, b_r});
    // remainder after a successful subtract is < b_r, so WIDTH bits suffice
    div_sub  = div_sh[WIDTH-1:0] - b_r;
    div_next = {(div_ge ? div_sub : div_sh[WIDTH-1:0]), p[WIDTH-2:0], div_ge};
  end

`ifdef ALU_FLAGS_EN
  logic [3:0] flags_r;
  logic       sc_c, sc_v;

  // carry/overflow for ADD and SUB; other single-cycle ops clear C and V
  always_comb begin
    sc_c = 1'b0;
    sc_v = 1'b0;
    if (opcode == 4'd0) begin
      sc_c = (sc_res < A);
      sc_v = (A[WIDTH-1] == B[WIDTH-1]) && (sc_res[WIDTH-1] != A[WIDTH-1]);
    end else if (opcode == 4'd1) begin
      sc_c = (A < B);
      sc_v = (A[WIDTH-1] != B[WIDTH-1]) && (sc_res[WIDTH-1] != A[WIDTH-1]);
    end
  end
  assign flags = iso_en ? 4'b0 : flags_r;
`else
  assign flags = 4'b0;
`endif

  // control FSM plus datapath/output registers; exactly one result write per edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      p           <= '0;
      b_r         <= '0;
      result_r    <= '0;
      result_hi_r <= '0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
`ifdef ALU_FLAGS_EN
      flags_r     <= 4'b0;
`endif
    end else begin
      done_r <= 1'b0;
      if (!alu_pwr_en) begin
        // abort: drop the op silently, keep the last visible results
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            cnt <= '0;
            b_r <= B;
            p   <= {{WIDTH{1'b0}}, A};
            if (opcode == 4'd8) begin
              state <= MUL_EXEC;
            end else if (opcode == 4'd9) begin
              if (B == '0) begin
                result_r    <= '1;
                result_hi_r <= A;
                err_r       <= 1'b1;
                done_r      <= 1'b1;
              end else begin
                state <= DIV_EXEC;
              end
            end else if (opcode > 4'd9) begin
              err_r  <= 1'b1;
              done_r <= 1'b1;
            end else begin
              result_r    <= sc_res;
              result_hi_r <= '0;
              err_r       <= 1'b0;
              done_r      <= 1'b1;
`ifdef ALU_FLAGS_EN
              flags_r     <= {sc_res[WIDTH-1], sc_res == '0, sc_c, sc_v};
`endif
            end
          end
          MUL_EXEC: begin
            p   <= mul_next;
            cnt <= cnt + 1'b1;
            if (last) begin
              state       <= IDLE;
              result_r    <= mul_next[WIDTH-1:0];
              result_hi_r <= mul_next[2*WIDTH-1:WIDTH];
              err_r       <= 1'b0;
              done_r      <= 1'b1;
`ifdef ALU_FLAGS_EN
              flags_r     <= {mul_next[WIDTH-1], mul_next[WIDTH-1:0] == '0,
                              mul_next[2*WIDTH-1:WIDTH] != '0, 1'b0};
`endif
            end
          end
          DIV_EXEC: begin
            p   <= div_next;
            cnt <= cnt + 1'b1;
            if (last) begin
              state       <= IDLE;
              result_r    <= div_next[WIDTH-1:0];
              result_hi_r <= div_next[2*WIDTH-1:WIDTH];
              err_r       <= 1'b0;
              done_r      <= 1'b1;
`ifdef ALU_FLAGS_EN
              flags_r     <= {div_next[WIDTH-1], div_next[WIDTH-1:0] == '0, 2'b00};
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // isolation clamp: outputs forced, internal state untouched
  assign result    = iso_en ? ISO_VAL : result_r;
  assign result_hi = iso_en ? ISO_VAL : result_hi_r;
  assign busy      = ~iso_en & run;
  assign done      = ~iso_en & done_r;
  assign err       = ~iso_en & err_r;
endmodule

// File: tb/tb_alu_mc_pipe.sv
// Directed bench for alu_mc_pipe at WIDTH=16 with hand-computed expectations.
module tb_alu_mc_pipe;
  logic        clk = 1'b0;
  logic        rst, alu_pwr_en, iso_en, start;
  logic [3:0]  opcode;
  logic [15:0] A, B;
  logic [15:0] result, result_hi;
  logic        busy, done, err;
  logic [3:0]  flags;

  int n_cmp = 0;
  int n_err = 0;

  alu_mc_pipe #(.WIDTH(16), .ISO_VAL(16'h0000)) dut (
    .clk(clk), .rst(rst), .alu_pwr_en(alu_pwr_en), .iso_en(iso_en),
    .start(start), .opcode(opcode), .A(A), .B(B),
    .result(result), .result_hi(result_hi), .busy(busy), .done(done),
    .err(err), .flags(flags)
  );

  always #5 clk = ~clk;

`ifdef ALU_FLAGS_EN
  localparam bit FL_EN = 1'b1;
`else
  localparam bit FL_EN = 1'b0;
`endif

  function automatic logic [3:0] fx(input logic [3:0] v);
    return FL_EN ? v : 4'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic go(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    start = 1'b1; opcode = op; A = a; B = b;
  endtask

  initial begin
    rst = 1'b1; alu_pwr_en = 1'b1; iso_en = 1'b0; start = 1'b0;
    opcode = 4'd0; A = '0; B = '0;
    #1;
    chk("rst_result", result, 0);
    chk("rst_hi", result_hi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_flags", flags, 0);
    @(negedge clk) rst = 1'b0;

    // ADD with signed overflow
    @(negedge clk) go(4'd0, 16'h7FFF, 16'h0001);
    @(negedge clk) start = 1'b0;
    chk("add_done", done, 1);
    chk("add_res", result, 16'h8000);
    chk("add_hi", result_hi, 0);
    chk("add_err", err, 0);
    chk("add_busy", busy, 0);
    chk("add_flags", flags, fx(4'b1001));
    @(negedge clk) chk("add_done_pulse", done, 0);

    // MUL, operands changed after accept, start pulsed while busy
    go(4'd8, 16'h1234, 16'h0100);
    @(negedge clk) start = 1'b0; A = 16'hFFFF; B = 16'hFFFF;
    chk("mul_busy0", busy, 1);
    chk("mul_done0", done, 0);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      chk("mul_busy", busy, 1);
      chk("mul_nodone", done, 0);
      if (i == 4) go(4'd0, 16'h0001, 16'h0001);
      else start = 1'b0;
    end
    @(negedge clk);
    chk("mul_done", done, 1);
    chk("mul_res", result, 16'h3400);
    chk("mul_hi", result_hi, 16'h0012);
    chk("mul_busy_end", busy, 0);
    chk("mul_err", err, 0);
    chk("mul_flags", flags, fx(4'b0010));
    @(negedge clk) chk("mul_done_pulse", done, 0);

    // DIV 1000/7
    go(4'd9, 16'd1000, 16'd7);
    @(negedge clk) start = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      chk("div_busy", busy, 1);
      chk("div_nodone", done, 0);
    end
    @(negedge clk);
    chk("div_done", done, 1);
    chk("div_q", result, 16'd142);
    chk("div_r", result_hi, 16'd6);
    chk("div_err", err, 0);
    chk("div_flags", flags, 4'b0000);

    // DIV by zero, issued in the cycle after done
    go(4'd9, 16'd5, 16'd0);
    @(negedge clk) start = 1'b0;
    chk("dz_done", done, 1);
    chk("dz_res", result, 16'hFFFF);
    chk("dz_hi", result_hi, 16'd5);
    chk("dz_err", err, 1);
    chk("dz_busy", busy, 0);
    chk("dz_flags", flags, 4'b0000);

    // SUB wrap with borrow
    @(negedge clk) go(4'd1, 16'd3, 16'd5);
    @(negedge clk) start = 1'b0;
    chk("sub_res", result, 16'hFFFE);
    chk("sub_err", err, 0);
    chk("sub_flags", flags, fx(4'b1010));

    // SLL uses only B[3:0]
    @(negedge clk) go(4'd6, 16'h0001, 16'h0014);
    @(negedge clk) start = 1'b0;
    chk("sll_res", result, 16'h0010);
    chk("sll_flags", flags, fx(4'b0000));

    // ADD then illegal opcode leaves result alone
    @(negedge clk) go(4'd0, 16'd2, 16'd3);
    @(negedge clk) go(4'hC, 16'h1111, 16'h2222);
    chk("add2_res", result, 16'd5);
    chk("add2_err", err, 0);
    @(negedge clk) start = 1'b0;
    chk("ill_done", done, 1);
    chk("ill_err", err, 1);
    chk("ill_res", result, 16'd5);
    chk("ill_hi", result_hi, 0);
    chk("ill_flags", flags, 4'b0000);

    // power abort during MUL
    @(negedge clk) go(4'd8, 16'd3, 16'd4);
    @(negedge clk) start = 1'b0;
    repeat (3) @(negedge clk);
    chk("ab_busy_pre", busy, 1);
    alu_pwr_en = 1'b0;
    @(negedge clk);
    chk("ab_busy", busy, 0);
    go(4'd0, 16'd1, 16'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("ab_nodone", done, 0);
      chk("ab_nobusy", busy, 0);
    end
    start = 1'b0;
    chk("ab_res", result, 16'd5);
    chk("ab_err", err, 1);
    alu_pwr_en = 1'b1;
    @(negedge clk);
    chk("ab_res2", result, 16'd5);
    chk("ab_done2", done, 0);

    // isolation during DIV 100/10
    go(4'd9, 16'd100, 16'd10);
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    iso_en = 1'b1;
    @(negedge clk);
    chk("iso_res", result, 0);
    chk("iso_hi", result_hi, 0);
    chk("iso_busy", busy, 0);
    chk("iso_err", err, 0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk("iso_nodone", done, 0);
      chk("iso_res_clamp", result, 0);
      if (i == 16) go(4'd0, 16'd1, 16'd1);
      else start = 1'b0;
    end
    iso_en = 1'b0;
    #1;
    chk("iso_q", result, 16'd10);
    chk("iso_r", result_hi, 0);
    chk("iso_err_after", err, 0);
    chk("iso_no_replay", done, 0);
    chk("iso_idle", busy, 0);

    // reset mid-DIV
    @(negedge clk) go(4'd9, 16'd1000, 16'd7);
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rd_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("rd_res", result, 0);
    chk("rd_hi", result_hi, 0);
    chk("rd_busy", busy, 0);
    chk("rd_done", done, 0);
    chk("rd_err", err, 0);
    chk("rd_flags", flags, 0);
    @(negedge clk) rst = 1'b0;
    repeat (17) @(negedge clk) chk("rd_nodone", done, 0);
    chk("rd_res_after", result, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
